// File: rtl/anton_neopixel_stream_decoder.sv
// WS2812-style single-wire receiver clocked by the 6.4 MHz slow clock.
// Measures high-pulse widths, assembles 24-bit MSB-first pixels and detects the latch gap.
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef RESET_DELAY_DEFAULT
`define RESET_DELAY_DEFAULT 320
`endif

module anton_neopixel_stream_decoder #(
    parameter int BUFFER_END    = `BUFFER_END_DEFAULT,
    parameter int RESET_DELAY   = `RESET_DELAY_DEFAULT,
    parameter int BIT_THRESHOLD = 4,
    localparam int BUFFER_BITS  = $clog2(BUFFER_END + 1)
) (
    input  logic                   clk6_4mhz,
    input  logic                   rst,
    input  logic                   streamInput,
    input  logic                   regCtrl32bit,
    input  logic                   errClear,
    output logic [23:0]            pixelData,
    output logic                   pixelValid,
    output logic [BUFFER_BITS-1:0] pixelIndex,
    output logic                   frameDone,
    output logic [BUFFER_BITS:0]   framePixels,
    output logic                   synced,
    output logic                   errLongHigh,
    output logic                   errPartialPixel,
    output logic                   errOverflow
);

    typedef enum logic {SYNC, ACTIVE} state_t;

    localparam logic [11:0]          LOW_MAX = 12'(RESET_DELAY);
    localparam logic [BUFFER_BITS:0] END_IDX = (BUFFER_BITS + 1)'(BUFFER_END);

    state_t state, stateNext;

    logic        s1, s2, s3;
    logic        rise, fall;
    logic [3:0]  highCount;
    logic [11:0] lowCount;
    logic        gapDone;
    logic        gapEvent;

    logic [4:0]             bitIndex, bitIndexNext;
    logic [23:0]            shifter, shifterNext;
    logic [BUFFER_BITS-1:0] writeIndex, writeIndexNext;
    logic                   indexFull, indexFullNext;
    logic [BUFFER_BITS:0]   pixelCount, pixelCountNext;

    logic [23:0]            pixelDataNext;
    logic                   pixelValidNext;
    logic [BUFFER_BITS-1:0] pixelIndexNext;
    logic                   frameDoneNext;
    logic [BUFFER_BITS:0]   framePixelsNext;
    logic                   setLongHigh, setPartial, setOverflow;

    logic                   bitValue;
    logic [23:0]            shiftedPixel;
    logic [BUFFER_BITS:0]   stepSize;
    logic [BUFFER_BITS:0]   sumIndex;
    logic [BUFFER_BITS-1:0] wordEnd;
    logic                   accept;

    assign rise     = !s3 && s2;
    assign fall     = s3 && !s2;
    // Fires once per gap: on the first cycle the low counter sits at its limit.
    assign gapEvent = (lowCount == LOW_MAX) && !gapDone;
    assign synced   = (state == ACTIVE);

    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            s1        <= 1'b0;
            s2        <= 1'b0;
            s3        <= 1'b0;
            highCount <= '0;
            lowCount  <= '0;
            gapDone   <= 1'b0;
        end else begin
            s1 <= streamInput;
            s2 <= s1;
            s3 <= s2;
            if (rise) begin
                highCount <= 4'd1;
            end else if (s2 && highCount != 4'd15) begin
                highCount <= highCount + 4'd1;
            end
            if (rise) begin
                lowCount <= '0;
            end else if (!s2 && lowCount != LOW_MAX) begin
                lowCount <= lowCount + 12'd1;
            end
            if (rise) begin
                gapDone <= 1'b0;
            end else if (gapEvent) begin
                gapDone <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk6_4mhz) begin
        if (rst) begin
            state           <= SYNC;
            bitIndex        <= '0;
            shifter         <= '0;
            writeIndex      <= '0;
            indexFull       <= 1'b0;
            pixelCount      <= '0;
            pixelData       <= '0;
            pixelValid      <= 1'b0;
            pixelIndex      <= '0;
            frameDone       <= 1'b0;
            framePixels     <= '0;
            errLongHigh     <= 1'b0;
            errPartialPixel <= 1'b0;
            errOverflow     <= 1'b0;
        end else begin
            state           <= stateNext;
            bitIndex        <= bitIndexNext;
            shifter         <= shifterNext;
            writeIndex      <= writeIndexNext;
            indexFull       <= indexFullNext;
            pixelCount      <= pixelCountNext;
            pixelData       <= pixelDataNext;
            pixelValid      <= pixelValidNext;
            pixelIndex      <= pixelIndexNext;
            frameDone       <= frameDoneNext;
            framePixels     <= framePixelsNext;
            // A new error in the same cycle as errClear keeps the flag set.
            errLongHigh     <= (errLongHigh && !errClear) || setLongHigh;
            errPartialPixel <= (errPartialPixel && !errClear) || setPartial;
            errOverflow     <= (errOverflow && !errClear) || setOverflow;
        end
    end

    always_comb begin
        bitValue     = (highCount >= 4'(BIT_THRESHOLD));
        shiftedPixel = {shifter[22:0], bitValue};
        stepSize     = regCtrl32bit ? (BUFFER_BITS + 1)'(4) : (BUFFER_BITS + 1)'(1);
        sumIndex     = {1'b0, writeIndex} + stepSize;
        wordEnd      = regCtrl32bit ? (writeIndex | BUFFER_BITS'(3)) : writeIndex;
        // indexFull records a carry out of the index so it can never wrap back to 0.
        accept       = !indexFull && ({1'b0, wordEnd} <= END_IDX);

        stateNext       = state;
        bitIndexNext    = bitIndex;
        shifterNext     = shifter;
        writeIndexNext  = writeIndex;
        indexFullNext   = indexFull;
        pixelCountNext  = pixelCount;
        pixelDataNext   = pixelData;
        pixelValidNext  = 1'b0;
        pixelIndexNext  = pixelIndex;
        frameDoneNext   = 1'b0;
        framePixelsNext = framePixels;
        setLongHigh     = 1'b0;
        setPartial      = 1'b0;
        setOverflow     = 1'b0;

        case (state)
            SYNC: begin
                if (gapEvent) begin
                    stateNext = ACTIVE;
                end
            end
            ACTIVE: begin
                if (gapEvent) begin
                    setPartial = (bitIndex != 5'd0);
                    if (pixelCount != '0) begin
                        frameDoneNext   = 1'b1;
                        framePixelsNext = pixelCount;
                    end
                    bitIndexNext   = '0;
                    writeIndexNext = '0;
                    indexFullNext  = 1'b0;
                    pixelCountNext = '0;
                end else if (fall) begin
                    if (highCount >= 4'd8) begin
                        setLongHigh  = 1'b1;
                        bitIndexNext = '0;
                    end else begin
                        shifterNext = shiftedPixel;
                        if (bitIndex == 5'd23) begin
                            bitIndexNext = '0;
                            if (accept) begin
                                pixelDataNext  = shiftedPixel;
                                pixelValidNext = 1'b1;
                                pixelIndexNext = writeIndex;
                                writeIndexNext = sumIndex[BUFFER_BITS-1:0];
                                indexFullNext  = sumIndex[BUFFER_BITS];
                                pixelCountNext = pixelCount + 1'b1;
                            end else begin
                                setOverflow = 1'b1;
                            end
                        end else begin
                            bitIndexNext = bitIndex + 5'd1;
                        end
                    end
                end
            end
            default: stateNext = SYNC;
        endcase
    end

endmodule

// File: tb/tb_anton_neopixel_stream_decoder.sv
// Directed bench for the NeoPixel stream decoder: drives pulse-width coded bits and checks
// decoded pixels, addresses, frame ends, latencies and sticky error flags.
module tb_anton_neopixel_stream_decoder;

    localparam int BE = 7;
    localparam int RD = 20;
    localparam int BB = 3;
    localparam int PW = BB + 24;

    logic          clk6_4mhz = 1'b0;
    logic          rst;
    logic          streamInput;
    logic          regCtrl32bit;
    logic          errClear;
    logic [23:0]   pixelData;
    logic          pixelValid;
    logic [BB-1:0] pixelIndex;
    logic          frameDone;
    logic [BB:0]   framePixels;
    logic          synced;
    logic          errLongHigh;
    logic          errPartialPixel;
    logic          errOverflow;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int lastFall    = 0;

    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] got_q[$];
    int            pixLat_q[$];
    logic [BB:0]   frame_q[$];
    int            frameLat_q[$];

    anton_neopixel_stream_decoder #(
        .BUFFER_END   (BE),
        .RESET_DELAY  (RD),
        .BIT_THRESHOLD(4)
    ) dut (
        .clk6_4mhz      (clk6_4mhz),
        .rst            (rst),
        .streamInput    (streamInput),
        .regCtrl32bit   (regCtrl32bit),
        .errClear       (errClear),
        .pixelData      (pixelData),
        .pixelValid     (pixelValid),
        .pixelIndex     (pixelIndex),
        .frameDone      (frameDone),
        .framePixels    (framePixels),
        .synced         (synced),
        .errLongHigh    (errLongHigh),
        .errPartialPixel(errPartialPixel),
        .errOverflow    (errOverflow)
    );

    always #5 clk6_4mhz = ~clk6_4mhz;

    always @(posedge clk6_4mhz) cyc <= cyc + 1;

    // Pulse capture: latencies are measured in clock edges from the last raw falling edge.
    always @(negedge clk6_4mhz) begin
        if (pixelValid) begin
            got_q.push_back({pixelIndex, pixelData});
            pixLat_q.push_back(cyc - lastFall);
        end
        if (frameDone) begin
            frame_q.push_back(framePixels);
            frameLat_q.push_back(cyc - lastFall);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk6_4mhz);
        #1;
    endtask

    task automatic sendRaw(input int h, input int l);
        streamInput = 1'b1;
        repeat (h) @(posedge clk6_4mhz);
        #1;
        streamInput = 1'b0;
        lastFall = cyc;
        repeat (l) @(posedge clk6_4mhz);
        #1;
    endtask

    task automatic sendBits(input logic [23:0] data, input int count);
        for (int i = 23; i > 23 - count; i--) begin
            if (data[i]) sendRaw(6, 2);
            else         sendRaw(2, 6);
        end
    endtask

    task automatic expectPixel(input logic [BB-1:0] idx, input logic [23:0] data);
        exp_q.push_back({idx, data});
    endtask

    task automatic checkPixels(input string tag);
        logic [PW-1:0] g;
        logic [PW-1:0] e;
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_pixel"}, 32'(g), 32'(e));
            check({tag, "_latency"}, 32'(pixLat_q.pop_front()), 32'd3);
        end
        got_q.delete();
        exp_q.delete();
        pixLat_q.delete();
    endtask

    task automatic checkFrame(input string tag, input int expPixels);
        check({tag, "_frames"}, 32'(frame_q.size()), 32'd1);
        if (frame_q.size() > 0) begin
            check({tag, "_framePixels"}, 32'(frame_q.pop_front()), 32'(expPixels));
            check({tag, "_frameLatency"}, 32'(frameLat_q.pop_front()), 32'(RD + 3));
        end
        frame_q.delete();
        frameLat_q.delete();
    endtask

    task automatic checkNoFrame(input string tag);
        check({tag, "_noFrame"}, 32'(frame_q.size()), 32'd0);
        frame_q.delete();
        frameLat_q.delete();
    endtask

    task automatic pulseErrClear;
        errClear = 1'b1;
        @(posedge clk6_4mhz);
        #1;
        errClear = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        streamInput  = 1'b0;
        regCtrl32bit = 1'b0;
        errClear     = 1'b0;
        repeat (3) @(posedge clk6_4mhz);
        #1;
        check("rst_pixelData", 32'(pixelData), 32'h0);
        check("rst_pixelValid", 32'(pixelValid), 32'h0);
        check("rst_pixelIndex", 32'(pixelIndex), 32'h0);
        check("rst_frameDone", 32'(frameDone), 32'h0);
        check("rst_framePixels", 32'(framePixels), 32'h0);
        check("rst_synced", 32'(synced), 32'h0);
        check("rst_errLongHigh", 32'(errLongHigh), 32'h0);
        check("rst_errPartial", 32'(errPartialPixel), 32'h0);
        check("rst_errOverflow", 32'(errOverflow), 32'h0);
        rst = 1'b0;

        // Bits before the first gap are ignored.
        sendBits(24'hFFFFFF, 24);
        idle(4);
        check("unsync_synced", 32'(synced), 32'h0);
        checkPixels("unsync");
        idle(RD + 5);
        check("sync_synced", 32'(synced), 32'h1);
        checkNoFrame("sync");
        check("sync_errPartial", 32'(errPartialPixel), 32'h0);

        // Single pixel.
        sendBits(24'hA5C33C, 24);
        expectPixel(3'd0, 24'hA5C33C);
        idle(RD + 6);
        checkPixels("single");
        checkFrame("single", 1);
        check("single_pixelIndex", 32'(pixelIndex), 32'h0);

        // Three pixels, 8-bit stepping, then a fresh frame restarts at index 0.
        sendBits(24'h123456, 24);
        sendBits(24'hFEDCBA, 24);
        sendBits(24'h0F0F0F, 24);
        expectPixel(3'd0, 24'h123456);
        expectPixel(3'd1, 24'hFEDCBA);
        expectPixel(3'd2, 24'h0F0F0F);
        idle(RD + 6);
        checkPixels("three");
        checkFrame("three", 3);
        sendBits(24'h800001, 24);
        expectPixel(3'd0, 24'h800001);
        idle(RD + 6);
        checkPixels("restart");
        checkFrame("restart", 1);
        check("hold_pixelData", 32'(pixelData), 32'h800001);

        // 32-bit stepping: third pixel lies beyond BUFFER_END.
        regCtrl32bit = 1'b1;
        sendBits(24'h111111, 24);
        sendBits(24'h222222, 24);
        sendBits(24'h333333, 24);
        expectPixel(3'd0, 24'h111111);
        expectPixel(3'd4, 24'h222222);
        idle(RD + 6);
        checkPixels("word");
        checkFrame("word", 2);
        check("word_errOverflow", 32'(errOverflow), 32'h1);
        check("word_holdIndex", 32'(pixelIndex), 32'h4);
        check("word_holdData", 32'(pixelData), 32'h222222);
        pulseErrClear();
        check("word_errClear", 32'(errOverflow), 32'h0);
        regCtrl32bit = 1'b0;

        // Gap after 10 bits.
        sendBits(24'hAAAAAA, 10);
        idle(RD + 6);
        checkPixels("partial");
        checkNoFrame("partial");
        check("partial_errPartial", 32'(errPartialPixel), 32'h1);
        pulseErrClear();
        check("partial_errClear", 32'(errPartialPixel), 32'h0);

        // 9-tick high mid-pixel restarts the bit count.
        sendBits(24'hFFFFFF, 5);
        sendRaw(9, 2);
        sendBits(24'hC0FFEE, 24);
        expectPixel(3'd0, 24'hC0FFEE);
        idle(RD + 6);
        checkPixels("longhigh");
        checkFrame("longhigh", 1);
        check("longhigh_err", 32'(errLongHigh), 32'h1);
        check("longhigh_noPartial", 32'(errPartialPixel), 32'h0);
        pulseErrClear();
        check("longhigh_errClear", 32'(errLongHigh), 32'h0);

        // Threshold sweep: 7 ticks -> 1 without error, then alternating 4 -> 1 and 3 -> 0.
        sendRaw(7, 4);
        for (int i = 1; i < 24; i++) begin
            if (i % 2 == 1) sendRaw(4, 4);
            else            sendRaw(3, 4);
        end
        expectPixel(3'd0, 24'hD55555);
        idle(RD + 6);
        checkPixels("threshold");
        checkFrame("threshold", 1);
        check("threshold_noLongHigh", 32'(errLongHigh), 32'h0);

        // Exactly 8 high ticks is already an error.
        sendRaw(8, 4);
        idle(RD + 6);
        check("eight_errLongHigh", 32'(errLongHigh), 32'h1);
        checkPixels("eight");
        checkNoFrame("eight");
        pulseErrClear();

        // Reset mid-frame drops the partial pixel silently.
        sendBits(24'hFFFFFF, 10);
        rst = 1'b1;
        @(posedge clk6_4mhz);
        #1;
        rst = 1'b0;
        check("midrst_synced", 32'(synced), 32'h0);
        check("midrst_errPartial", 32'(errPartialPixel), 32'h0);
        check("midrst_pixelData", 32'(pixelData), 32'h0);
        idle(RD + 6);
        check("midrst_resynced", 32'(synced), 32'h1);
        checkPixels("midrst");
        checkNoFrame("midrst");
        check("midrst_noPartial", 32'(errPartialPixel), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
